// File: rtl/uart_wb_bridge.sv
// UART command parser that acts as a single-transfer pipelined wishbone master.
// Accepts 'W'/'R' byte commands from uart_rx and returns status/data bytes to uart_tx.
module uart_wb_bridge #(
   parameter int ADDR_W       = 30,
   parameter int BYTE_TIMEOUT = 1_000_000,
   parameter int BUS_TIMEOUT  = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              m_cyc,
   output logic              m_stb,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [3:0]        m_sel,
   output logic [31:0]       m_data_m2s,
   input  logic [31:0]       m_data_s2m,
   input  logic              m_ack,
   input  logic              m_err,
   input  logic              m_stall,
   output logic              busy,
   output logic              rx_drop
);

   localparam int BYTE_TW = $clog2(BYTE_TIMEOUT + 1);
   localparam int BUS_TW  = $clog2(BUS_TIMEOUT + 1);
   localparam logic [BYTE_TW-1:0] BYTE_LAST = BYTE_TW'(BYTE_TIMEOUT - 1);
   localparam logic [BUS_TW-1:0]  BUS_LAST  = BUS_TW'(BUS_TIMEOUT - 1);

   localparam logic [7:0] CMD_WR = 8'h57;
   localparam logic [7:0] CMD_RD = 8'h52;
   localparam logic [7:0] ST_ACK = 8'h06;
   localparam logic [7:0] ST_NAK = 8'h15;
   localparam logic [7:0] ST_TMO = 8'h54;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_WDATA,
      S_BUS_REQ,
      S_BUS_WAIT,
      S_RESP
   } state_t;

   state_t             r_state;
   logic               r_we;
   logic [31:0]        r_addr;
   logic [31:0]        r_wdata;
   logic [31:0]        r_rdata;
   logic [1:0]         r_byte_cnt;
   logic [BYTE_TW-1:0] r_byte_timer;
   logic [BUS_TW-1:0]  r_bus_timer;
   logic [7:0]         r_status;
   logic [2:0]         r_resp_idx;
   logic [2:0]         r_resp_last;
   logic               r_cyc;
   logic               r_stb;
   logic [3:0]         r_sel;
   logic               r_tx_valid;
   logic [7:0]         r_tx_data;
   logic               r_rx_drop;

   logic w_rx_cmd;
   logic w_stb_accept;
   logic w_bus_done;
   logic w_read_ok;

   assign w_rx_cmd     = rx_valid && (rx_data == CMD_WR || rx_data == CMD_RD);
   assign w_stb_accept = r_stb && !m_stall;
   // A response counts either in the accept cycle itself or any later wait cycle.
   assign w_bus_done   = (w_stb_accept || r_state == S_BUS_WAIT) && (m_ack || m_err);
   assign w_read_ok    = !m_err && !r_we;

   function automatic logic [7:0] f_resp_byte(input logic [2:0]  idx,
                                              input logic [7:0]  status,
                                              input logic [31:0] data);
      case (idx)
         3'd0:    return status;
         3'd1:    return data[31:24];
         3'd2:    return data[23:16];
         3'd3:    return data[15:8];
         default: return data[7:0];
      endcase
   endfunction

   // NOTE: every state register uses <= so all updates in a clock edge see the pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_rdata      <= '0;
         r_byte_cnt   <= '0;
         r_byte_timer <= '0;
         r_bus_timer  <= '0;
         r_status     <= '0;
         r_resp_idx   <= '0;
         r_resp_last  <= '0;
         r_cyc        <= 1'b0;
         r_stb        <= 1'b0;
         r_sel        <= '0;
         r_tx_valid   <= 1'b0;
         r_tx_data    <= '0;
         r_rx_drop    <= 1'b0;
      end else begin
         r_rx_drop <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_rx_cmd) begin
                  r_we         <= (rx_data == CMD_WR);
                  r_byte_cnt   <= '0;
                  r_byte_timer <= '0;
                  r_state      <= S_ADDR;
               end
            end

            S_ADDR, S_WDATA: begin
               if (rx_valid) begin
                  r_byte_timer <= '0;
                  r_byte_cnt   <= r_byte_cnt + 2'd1;
                  if (r_state == S_ADDR) r_addr  <= {r_addr[23:0], rx_data};
                  else                   r_wdata <= {r_wdata[23:0], rx_data};
                  if (r_byte_cnt == 2'd3) begin
                     if (r_state == S_ADDR && r_we) begin
                        r_state <= S_WDATA;
                     end else begin
                        r_state     <= S_BUS_REQ;
                        r_cyc       <= 1'b1;
                        r_stb       <= 1'b1;
                        r_sel       <= 4'hF;
                        r_bus_timer <= '0;
                     end
                  end
               end else if (r_byte_timer == BYTE_LAST) begin
                  r_state <= S_IDLE;
               end else begin
                  r_byte_timer <= r_byte_timer + 1'b1;
               end
            end

            S_BUS_REQ, S_BUS_WAIT: begin
               r_rx_drop <= rx_valid;
               if (w_stb_accept) r_stb <= 1'b0;
               if (w_bus_done) begin
                  r_cyc       <= 1'b0;
                  r_stb       <= 1'b0;
                  r_sel       <= '0;
                  r_status    <= m_err ? ST_NAK : ST_ACK;
                  r_resp_last <= w_read_ok ? 3'd4 : 3'd0;
                  r_resp_idx  <= '0;
                  if (w_read_ok) r_rdata <= m_data_s2m;
                  r_state     <= S_RESP;
               end else if (r_bus_timer == BUS_LAST) begin
                  r_cyc       <= 1'b0;
                  r_stb       <= 1'b0;
                  r_sel       <= '0;
                  r_status    <= ST_TMO;
                  r_resp_last <= 3'd0;
                  r_resp_idx  <= '0;
                  r_state     <= S_RESP;
               end else begin
                  r_bus_timer <= r_bus_timer + 1'b1;
                  if (w_stb_accept) r_state <= S_BUS_WAIT;
               end
            end

            S_RESP: begin
               r_rx_drop <= rx_valid;
               if (!r_tx_valid) begin
                  r_tx_valid <= 1'b1;
                  r_tx_data  <= f_resp_byte(r_resp_idx, r_status, r_rdata);
               end else if (tx_ready) begin
                  if (r_resp_idx == r_resp_last) begin
                     r_tx_valid <= 1'b0;
                     r_tx_data  <= '0;
                     r_state    <= S_IDLE;
                  end else begin
                     r_resp_idx <= r_resp_idx + 3'd1;
                     r_tx_data  <= f_resp_byte(r_resp_idx + 3'd1, r_status, r_rdata);
                  end
               end
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign m_cyc      = r_cyc;
   assign m_stb      = r_stb;
   assign m_we       = r_we;
   assign m_addr     = r_addr[ADDR_W+1:2];
   assign m_sel      = r_sel;
   assign m_data_m2s = r_wdata;
   assign tx_valid   = r_tx_valid;
   assign tx_data    = r_tx_data;
   assign rx_drop    = r_rx_drop;
   assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_wb_bridge.sv
// Bench for uart_wb_bridge: byte-level host driver, wishbone slave model and a
// response model derived from the command/status rules.
module tb_uart_wb_bridge;
   localparam int ADDR_W       = 30;
   localparam int BYTE_TIMEOUT = 40;
   localparam int BUS_TIMEOUT  = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic [7:0]        tx_data;
   logic              tx_valid;
   logic              tx_ready = 1'b0;
   logic              m_cyc;
   logic              m_stb;
   logic              m_we;
   logic [ADDR_W-1:0] m_addr;
   logic [3:0]        m_sel;
   logic [31:0]       m_data_m2s;
   logic [31:0]       m_data_s2m = '0;
   logic              m_ack = 1'b0;
   logic              m_err = 1'b0;
   logic              m_stall = 1'b0;
   logic              busy;
   logic              rx_drop;

   always #5 clk = ~clk;

   uart_wb_bridge #(
      .ADDR_W(ADDR_W), .BYTE_TIMEOUT(BYTE_TIMEOUT), .BUS_TIMEOUT(BUS_TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst),
      .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_addr(m_addr), .m_sel(m_sel),
      .m_data_m2s(m_data_m2s), .m_data_s2m(m_data_s2m),
      .m_ack(m_ack), .m_err(m_err), .m_stall(m_stall),
      .busy(busy), .rx_drop(rx_drop)
   );

   // Slave behaviour: mode 0-3 ack, 4 err, 5 silent, 6 ack+err together.
   int          cfg_mode   = 0;
   int          cfg_stall  = 0;
   int          cfg_rdelay = 0;
   bit          cfg_fast   = 1'b0;
   logic [31:0] cfg_rdata  = '0;

   function automatic bit mode_acks(input int m);
      return (m <= 3) || (m == 6);
   endfunction

   function automatic bit mode_errs(input int m);
      return (m == 4) || (m == 6);
   endfunction

   int stall_left = 0;
   bit pending    = 1'b0;
   int rwait      = 0;

   always @(negedge clk) begin
      m_ack <= 1'b0;
      m_err <= 1'b0;
      if (rst || !m_cyc) begin
         m_stall    <= 1'b0;
         pending    <= 1'b0;
         stall_left <= cfg_stall;
      end else if (pending) begin
         pending    <= 1'b0;
         m_ack      <= mode_acks(cfg_mode);
         m_err      <= mode_errs(cfg_mode);
         m_data_s2m <= mode_acks(cfg_mode) ? cfg_rdata : 32'hBAD0BAD0;
      end else if (m_stb) begin
         if (stall_left > 0) begin
            m_stall    <= 1'b1;
            stall_left <= stall_left - 1;
         end else begin
            m_stall <= 1'b0;
            if (cfg_fast) begin
               m_ack      <= mode_acks(cfg_mode);
               m_err      <= mode_errs(cfg_mode);
               m_data_s2m <= mode_acks(cfg_mode) ? cfg_rdata : 32'hBAD0BAD0;
            end else begin
               pending <= 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst || !tx_valid) begin
         tx_ready <= 1'b0;
         rwait    <= 0;
      end else if (rwait < cfg_rdelay) begin
         tx_ready <= 1'b0;
         rwait    <= rwait + 1;
      end else begin
         tx_ready <= 1'b1;
         rwait    <= 0;
      end
   end

   // Monitor: cumulative logs; cycle labels refer to the cycle ending at this edge.
   int              cyc_cnt = 0, last_rx = 0, cyc_rise = 0, cyc_fall = 0, tx_rise = 0;
   int              stb_cycles = 0, acc_cnt = 0, drop_cnt = 0, unstable_cnt = 0;
   bit              cyc_prev = 1'b0, tx_prev = 1'b0, hold_pending = 1'b0;
   logic [7:0]      hold_data = '0;
   logic [ADDR_W-1:0] acc_addr = '0;
   logic            acc_we = 1'b0;
   logic [3:0]      acc_sel = '0;
   logic [31:0]     acc_wdata = '0;
   logic [7:0]      got_q[$];
   logic [7:0]      exp_q[$];

   always @(posedge clk) begin
      cyc_cnt <= cyc_cnt + 1;
      if (rst) begin
         cyc_prev     <= 1'b0;
         tx_prev      <= 1'b0;
         hold_pending <= 1'b0;
      end else begin
         if (rx_valid) last_rx <= cyc_cnt;
         if (m_cyc && !cyc_prev) cyc_rise <= cyc_cnt;
         if (!m_cyc && cyc_prev) cyc_fall <= cyc_cnt;
         if (tx_valid && !tx_prev) tx_rise <= cyc_cnt;
         cyc_prev <= m_cyc;
         tx_prev  <= tx_valid;
         if (m_cyc && m_stb) stb_cycles <= stb_cycles + 1;
         if (m_cyc && m_stb && !m_stall) begin
            acc_cnt   <= acc_cnt + 1;
            acc_addr  <= m_addr;
            acc_we    <= m_we;
            acc_sel   <= m_sel;
            acc_wdata <= m_data_m2s;
         end
         if (tx_valid && tx_ready) got_q.push_back(tx_data);
         if (hold_pending && !(tx_valid && tx_data == hold_data)) unstable_cnt <= unstable_cnt + 1;
         hold_pending <= tx_valid && !tx_ready;
         hold_data    <= tx_data;
         if (rx_drop) drop_cnt <= drop_cnt + 1;
      end
   end

   int n_assert = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic void build_exp(input bit we, input int mode, input logic [31:0] rd);
      exp_q.delete();
      if (mode == 5) begin
         exp_q.push_back(8'h54);
      end else if (mode_errs(mode)) begin
         exp_q.push_back(8'h15);
      end else begin
         exp_q.push_back(8'h06);
         if (!we) for (int i = 3; i >= 0; i--) exp_q.push_back(rd[8*i +: 8]);
      end
   endfunction

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
   endtask

   task automatic send_cmd(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
      send_byte(we ? 8'h57 : 8'h52);
      for (int i = 3; i >= 0; i--) send_byte(addr[8*i +: 8]);
      if (we) for (int i = 3; i >= 0; i--) send_byte(wdata[8*i +: 8]);
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      @(negedge clk);
      while ((busy || tx_valid) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("idle_wait", 32'(n < budget), 32'd1);
   endtask

   task automatic run_cmd(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input int mode, input int stall, input bit fast, input int rdelay,
                          input logic [31:0] rdata, input bit inject_drop);
      int got_base, acc_base, stb_base, drop_base, lr, n;
      cfg_mode   = mode;
      cfg_stall  = stall;
      cfg_fast   = fast;
      cfg_rdelay = rdelay;
      cfg_rdata  = rdata;
      got_base   = got_q.size();
      acc_base   = acc_cnt;
      stb_base   = stb_cycles;
      drop_base  = drop_cnt;
      send_cmd(we, addr, wdata);
      lr = last_rx;
      if (inject_drop) begin
         n = 0;
         while (!tx_valid && n < BUS_TIMEOUT + 100) begin
            @(negedge clk);
            n++;
         end
         check("drop_wait_tx", 32'(n < BUS_TIMEOUT + 100), 32'd1);
         send_byte(8'h57);
      end
      wait_idle(BUS_TIMEOUT + 200);
      build_exp(we, mode, rdata);
      check("acc_count", acc_cnt - acc_base, 32'd1);
      check("stb_cycles", stb_cycles - stb_base, stall + 1);
      check("bus_addr", 32'(acc_addr), {2'b00, addr[31:2]});
      check("bus_we", 32'(acc_we), 32'(we));
      check("bus_sel", 32'(acc_sel), 32'hF);
      if (we) check("bus_wdata", acc_wdata, wdata);
      check("resp_len", got_q.size() - got_base, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         if (got_base + i < got_q.size()) check("resp_byte", 32'(got_q[got_base + i]), 32'(exp_q[i]));
      check("bus_latency", cyc_rise - lr, 32'd1);
      check("tx_latency", tx_rise - cyc_fall, 32'd1);
      if (mode == 5) check("timeout_len", cyc_fall - cyc_rise, BUS_TIMEOUT);
      check("tx_stable", unstable_cnt, 32'd0);
      check("rx_drop_cnt", drop_cnt - drop_base, 32'(inject_drop));
   endtask

   initial begin
      int          acc_base, got_base, n;
      bit          r_we, r_fast;
      int          r_mode, r_stall, r_rdelay;
      logic [31:0] r_addr, r_wdata, r_rdata;

      rst      = 1'b1;
      rx_valid = 1'b0;
      rx_data  = '0;
      repeat (3) @(negedge clk);
      check("rst_m_cyc", 32'(m_cyc), 32'd0);
      check("rst_m_stb", 32'(m_stb), 32'd0);
      check("rst_m_we", 32'(m_we), 32'd0);
      check("rst_m_sel", 32'(m_sel), 32'd0);
      check("rst_m_addr", 32'(m_addr), 32'd0);
      check("rst_m_wdata", m_data_m2s, 32'd0);
      check("rst_tx_valid", 32'(tx_valid), 32'd0);
      check("rst_tx_data", 32'(tx_data), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rx_drop", 32'(rx_drop), 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      run_cmd(1'b1, 32'h0000_1008, 32'hDEAD_BEEF, 0, 0, 1'b0, 0, 32'h0, 1'b0);
      check("wr_addr_402", 32'(acc_addr), 32'h402);

      run_cmd(1'b0, 32'h0000_0004, 32'h0, 0, 3, 1'b0, 5, 32'h1234_5678, 1'b0);
      run_cmd(1'b0, 32'h0000_0100, 32'h0, 4, 0, 1'b0, 0, 32'h0, 1'b0);
      run_cmd(1'b0, 32'h0000_0200, 32'h0, 5, 0, 1'b0, 0, 32'h0, 1'b0);
      run_cmd(1'b1, 32'h0000_0010, 32'h0BAD_F00D, 6, 1, 1'b1, 1, 32'h0, 1'b0);

      send_byte(8'h41);
      check("ignore_0x41_busy", 32'(busy), 32'd0);
      run_cmd(1'b0, 32'h0000_0040, 32'h0, 0, 1, 1'b1, 0, 32'hCAFE_F00D, 1'b0);

      acc_base = acc_cnt;
      got_base = got_q.size();
      send_byte(8'h57);
      send_byte(8'h00);
      send_byte(8'h00);
      repeat (BYTE_TIMEOUT - 10) @(negedge clk);
      check("bto_still_busy", 32'(busy), 32'd1);
      repeat (20) @(negedge clk);
      check("bto_idle", 32'(busy), 32'd0);
      check("bto_no_bus", acc_cnt - acc_base, 32'd0);
      check("bto_no_tx", got_q.size() - got_base, 32'd0);

      cfg_mode  = 5;
      cfg_stall = 0;
      cfg_fast  = 1'b0;
      send_cmd(1'b0, 32'h0000_0300, 32'h0);
      n = 0;
      while (!m_cyc && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("rst_wait_cyc", 32'(n < 100), 32'd1);
      repeat (3) @(posedge clk);
      #1;
      check("pre_rst_busy", 32'(busy), 32'd1);
      check("pre_rst_cyc", 32'(m_cyc), 32'd1);
      #1 rst = 1'b1;
      #1;
      check("async_rst_cyc", 32'(m_cyc), 32'd0);
      check("async_rst_stb", 32'(m_stb), 32'd0);
      check("async_rst_txv", 32'(tx_valid), 32'd0);
      check("async_rst_busy", 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      run_cmd(1'b0, 32'h0000_0080, 32'h0, 0, 0, 1'b0, 5, 32'hA5A5_5A5A, 1'b1);

      for (int k = 0; k < 12; k++) begin
         r_we     = 1'($urandom_range(0, 1));
         r_addr   = $urandom;
         r_wdata  = $urandom;
         r_rdata  = $urandom;
         r_mode   = int'($urandom_range(0, 6));
         r_stall  = int'($urandom_range(0, 3));
         r_fast   = 1'($urandom_range(0, 1));
         r_rdelay = int'($urandom_range(0, 2));
         run_cmd(r_we, r_addr, r_wdata, r_mode, r_stall, r_fast, r_rdelay, r_rdata, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
